// File: rtl/mac_array_stream_if.sv
// rtl/mac_array_stream_if.sv - activation/weight input stream and result output handshake
interface mac_array_stream_if #(
  parameter int N_CH  = 10,
  parameter int IN_W  = 8,
  parameter int W_W   = 8,
  parameter int OUT_W = 24
);
  logic                    inValid;
  logic                    inReady;
  logic [IN_W-1:0]         actIn;
  logic [N_CH*W_W-1:0]     weightsIn;
  logic [N_CH*OUT_W-1:0]   sumOut;
  logic                    outValid;
  logic                    outReady;

  modport slave (
    input  inValid, actIn, weightsIn, outReady,
    output inReady, sumOut, outValid
  );

  modport master (
    output inValid, actIn, weightsIn, outReady,
    input  inReady, sumOut, outValid
  );
endinterface

// File: rtl/mac_array_stream.sv
// rtl/mac_array_stream.sv - N_CH saturating signed MAC channels over a shared unsigned activation stream
module mac_array_stream #(
  parameter int N_CH  = 10,
  parameter int IN_W  = 8,
  parameter int W_W   = 8,
  parameter int OUT_W = 24,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                biasLoad,
  input  logic [N_CH*W_W-1:0] biasIn,
  input  logic                start,
  output logic [N_CH-1:0]     overflow,
  output logic                busy,
  mac_array_stream_if.slave   s
);

  localparam int PROD_W = W_W + IN_W + 1;
  localparam int EXT_W  = ((OUT_W > PROD_W) ? OUT_W : PROD_W) + 1;
  localparam logic [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [OUT_W-1:0]          r_acc  [N_CH];
  logic [OUT_W-1:0]          r_bias [N_CH];
  logic [OUT_W-1:0]          r_sum  [N_CH];
  logic [N_CH-1:0]           r_ovf;
  logic [CNT_W-1:0]          r_cnt;

  logic                      w_accept;
  logic                      w_last;
  logic [OUT_W-1:0]          w_bias_new [N_CH];
  logic [OUT_W-1:0]          w_seed     [N_CH];
  logic signed [PROD_W-1:0]  w_prod     [N_CH];
  logic signed [EXT_W-1:0]   w_sum      [N_CH];
  logic [OUT_W-1:0]          w_sat      [N_CH];
  logic [N_CH-1:0]           w_clamp;

  assign w_accept = s.inValid && (r_state == S_ACCUM);
  assign w_last   = (r_cnt == CNT_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ACCUM;
      S_ACCUM: if (w_accept && w_last) w_next = S_DONE;
      S_DONE:  if (s.outReady) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    s.inReady  = (r_state == S_ACCUM);
    s.outValid = (r_state == S_DONE);
    busy       = (r_state != S_IDLE);
  end

  // Sum is formed one bit wider than either operand so the clamp sees the true value.
  always_comb begin
    w_clamp = '0;
    for (int m = 0; m < N_CH; m++) begin
      w_bias_new[m] = {{(OUT_W-W_W){biasIn[m*W_W+W_W-1]}}, biasIn[m*W_W +: W_W]};
      w_seed[m]     = biasLoad ? w_bias_new[m] : r_bias[m];
      w_prod[m]     = $signed({{(PROD_W-W_W){s.weightsIn[m*W_W+W_W-1]}}, s.weightsIn[m*W_W +: W_W]})
                    * $signed({{(PROD_W-IN_W){1'b0}}, s.actIn});
      w_sum[m]      = $signed({{(EXT_W-OUT_W){r_acc[m][OUT_W-1]}}, r_acc[m]})
                    + $signed({{(EXT_W-PROD_W){w_prod[m][PROD_W-1]}}, w_prod[m]});
      if (w_sum[m] > $signed(SAT_MAX)) begin
        w_sat[m]   = SAT_MAX[OUT_W-1:0];
        w_clamp[m] = 1'b1;
      end else if (w_sum[m] < $signed(SAT_MIN)) begin
        w_sat[m]   = SAT_MIN[OUT_W-1:0];
        w_clamp[m] = 1'b1;
      end else begin
        w_sat[m]   = w_sum[m][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int m = 0; m < N_CH; m++) begin
        r_acc[m]  <= '0;
        r_bias[m] <= '0;
        r_sum[m]  <= '0;
      end
      r_ovf <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          for (int m = 0; m < N_CH; m++) begin
            if (biasLoad) r_bias[m] <= w_bias_new[m];
            if (start)    r_acc[m]  <= w_seed[m];
          end
          if (start) begin
            r_cnt <= '0;
            r_ovf <= '0;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            for (int m = 0; m < N_CH; m++) begin
              r_acc[m] <= w_sat[m];
              if (w_last) r_sum[m] <= w_sat[m];
            end
            r_ovf <= r_ovf | w_clamp;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s.sumOut = '0;
    for (int m = 0; m < N_CH; m++) s.sumOut[m*OUT_W +: OUT_W] = r_sum[m];
  end

  assign overflow = r_ovf;

endmodule

// File: tb/tb_mac_array_stream.sv
// tb/tb_mac_array_stream.sv - scoreboard bench driving a 24-bit and a 12-bit instance in lockstep
module tb_mac_array_stream;

  logic        clk = 1'b0;
  logic        clr, biasLoad, start, inValid, outReady;
  logic [15:0] biasIn, weightsIn;
  logic [7:0]  actIn;
  logic [1:0]  ovf_a, ovf_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  mac_array_stream_if #(.N_CH(2), .IN_W(8), .W_W(8), .OUT_W(24)) ia ();
  mac_array_stream_if #(.N_CH(2), .IN_W(8), .W_W(8), .OUT_W(12)) ib ();

  assign ia.inValid = inValid;   assign ib.inValid = inValid;
  assign ia.actIn = actIn;       assign ib.actIn = actIn;
  assign ia.weightsIn = weightsIn; assign ib.weightsIn = weightsIn;
  assign ia.outReady = outReady; assign ib.outReady = outReady;

  mac_array_stream #(.N_CH(2), .IN_W(8), .W_W(8), .OUT_W(24), .DEPTH(4)) dut_a (
    .clk(clk), .clr(clr), .biasLoad(biasLoad), .biasIn(biasIn), .start(start),
    .overflow(ovf_a), .busy(busy_a), .s(ia));

  mac_array_stream #(.N_CH(2), .IN_W(8), .W_W(8), .OUT_W(12), .DEPTH(4)) dut_b (
    .clk(clk), .clr(clr), .biasLoad(biasLoad), .biasIn(biasIn), .start(start),
    .overflow(ovf_b), .busy(busy_b), .s(ib));

  typedef struct {longint s0; longint s1; longint ovf;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic pa = 1'b0;
  logic pb = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic longint sa(input int ch);
    return longint'($signed(ia.sumOut[ch*24 +: 24]));
  endfunction

  function automatic longint sb(input int ch);
    return longint'($signed(ib.sumOut[ch*12 +: 12]));
  endfunction

  always @(negedge clk) begin
    if (ia.outValid === 1'b1 && !pa) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL mon_a unexpected result actual=%0d expected=none", sa(0));
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("mon_a_ch0", sa(0), e.s0);
        chk("mon_a_ch1", sa(1), e.s1);
        chk("mon_a_ovf", longint'(ovf_a), e.ovf);
      end
    end
    if (ib.outValid === 1'b1 && !pb) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL mon_b unexpected result actual=%0d expected=none", sb(0));
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("mon_b_ch0", sb(0), e.s0);
        chk("mon_b_ch1", sb(1), e.s1);
        chk("mon_b_ovf", longint'(ovf_b), e.ovf);
      end
    end
    pa = (ia.outValid === 1'b1);
    pb = (ib.outValid === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input longint a0, a1, aov, b0, b1, bov);
    qa.push_back('{a0, a1, aov});
    qb.push_back('{b0, b1, bov});
  endtask

  task automatic go(input logic ld, input logic [7:0] b0, b1);
    start = 1'b1; biasLoad = ld; biasIn = {b1, b0};
    tick();
    start = 1'b0; biasLoad = 1'b0;
  endtask

  task automatic beat(input logic [7:0] w0, w1, a);
    int t;
    t = 0;
    inValid = 1'b1; weightsIn = {w1, w0}; actIn = a;
    while (!(ia.inReady && ib.inReady) && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) chk("beat_timeout", longint'(t), 0);
    tick();
    inValid = 1'b0;
  endtask

  initial begin
    int t;
    clr = 1'b1; biasLoad = 1'b0; start = 1'b0; inValid = 1'b0; outReady = 1'b1;
    biasIn = '0; weightsIn = '0; actIn = '0;

    // reset with random inputs
    clr = 1'b0;
    repeat (2) begin
      biasLoad = 1'($urandom); start = 1'($urandom); inValid = 1'($urandom);
      actIn = 8'($urandom); weightsIn = 16'($urandom); biasIn = 16'($urandom);
      outReady = 1'($urandom);
      tick();
    end
    chk("rst_outValid_a", longint'(ia.outValid), 0);
    chk("rst_outValid_b", longint'(ib.outValid), 0);
    chk("rst_inReady_a", longint'(ia.inReady), 0);
    chk("rst_inReady_b", longint'(ib.inReady), 0);
    chk("rst_busy_a", longint'(busy_a), 0);
    chk("rst_busy_b", longint'(busy_b), 0);
    chk("rst_sum_a", longint'(ia.sumOut), 0);
    chk("rst_sum_b", longint'(ib.sumOut), 0);
    chk("rst_ovf_a", longint'(ovf_a), 0);
    chk("rst_ovf_b", longint'(ovf_b), 0);
    clr = 1'b1; biasLoad = 1'b0; start = 1'b0; inValid = 1'b0; outReady = 1'b1;
    tick();

    // basic run: bias -5 / 2, act 10, w 3 / -2
    biasLoad = 1'b1; biasIn = {8'h02, 8'hFB};
    tick();
    biasLoad = 1'b0;
    go(1'b0, 8'h00, 8'h00);
    push(115, -78, 0, 115, -78, 0);
    repeat (3) beat(8'h03, 8'hFE, 8'd10);
    chk("lat_pre_a", longint'(ia.outValid), 0);
    beat(8'h03, 8'hFE, 8'd10);
    chk("lat_a", longint'(ia.outValid), 1);
    chk("lat_b", longint'(ib.outValid), 1);
    tick();
    chk("idle_busy_a", longint'(busy_a), 0);

    // handshake stress: gaps between beats, output held back
    go(1'b0, 8'h00, 8'h00);
    push(115, -78, 0, 115, -78, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) outReady = 1'b0;
      beat(8'h03, 8'hFE, 8'd10);
      if (i < 3) tick();
    end
    repeat (5) begin
      chk("hold_valid_a", longint'(ia.outValid), 1);
      chk("hold_sum_a0", sa(0), 115);
      chk("hold_sum_b1", sb(1), -78);
      tick();
    end
    outReady = 1'b1;
    tick();
    chk("release_valid_a", longint'(ia.outValid), 0);
    chk("release_busy_b", longint'(busy_b), 0);

    // saturation: 12-bit instance clamps, 24-bit instance does not
    go(1'b1, 8'h00, 8'h00);
    push(129540, -130560, 0, 2047, -2048, 3);
    repeat (4) beat(8'h7F, 8'h80, 8'hFF);
    tick();
    go(1'b0, 8'h00, 8'h00);
    chk("ovf_clear_b", longint'(ovf_b), 0);
    push(0, 0, 0, 0, 0, 0);
    repeat (4) beat(8'h00, 8'h00, 8'h00);
    tick();

    // reset mid-run discards run and biases
    go(1'b1, 8'd3, 8'd9);
    repeat (2) beat(8'h01, 8'h00, 8'd5);
    clr = 1'b0;
    tick();
    tick();
    chk("midrst_inReady_a", longint'(ia.inReady), 0);
    chk("midrst_busy_b", longint'(busy_b), 0);
    chk("midrst_valid_a", longint'(ia.outValid), 0);
    clr = 1'b1;
    tick();
    go(1'b0, 8'h55, 8'h55);
    push(20, 0, 0, 20, 0, 0);
    repeat (4) beat(8'h01, 8'h00, 8'd5);
    tick();

    // start+biasLoad together; control ignored in ACCUM and DONE
    go(1'b1, 8'd7, 8'd3);
    push(7, 7, 0, 7, 7, 0);
    repeat (2) beat(8'h00, 8'h01, 8'd1);
    start = 1'b1; biasLoad = 1'b1; biasIn = 16'h5050;
    tick();
    start = 1'b0; biasLoad = 1'b0;
    beat(8'h00, 8'h01, 8'd1);
    outReady = 1'b0;
    beat(8'h00, 8'h01, 8'd1);
    start = 1'b1; biasLoad = 1'b1; biasIn = 16'h6060;
    repeat (2) begin
      chk("done_ctl_a0", sa(0), 7);
      chk("done_ctl_b1", sb(1), 7);
      tick();
    end
    start = 1'b0; biasLoad = 1'b0; outReady = 1'b1;
    tick();
    go(1'b0, 8'h00, 8'h00);
    push(7, 3, 0, 7, 3, 0);
    repeat (4) beat(8'h00, 8'h00, 8'h00);
    tick();

    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 50) begin
      tick();
      t++;
    end
    chk("drain", longint'(qa.size() + qb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
